// File: rtl/multi_channel_avg_filter.sv
// multi_channel_avg_filter: time-multiplexed moving average with one ring buffer and running sum per channel.
// Optional: `define SPIKE_CLAMP_EN to clamp samples on primed channels to avg +/- CLAMP_DELTA.
module multi_channel_avg_filter #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH = 8,
    parameter int CLAMP_DELTA = 16,
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
    localparam int LD = $clog2(DEPTH),
    localparam int SUM_W = DATA_W + LD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clr_valid,
    input  logic [CH_W-1:0]   clr_ch,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_avg,
    output logic              out_primed,
    output logic [NUM_CH-1:0] primed_mask
);
    localparam logic [LD:0] FULL = (LD + 1)'(DEPTH);
    if (DEPTH != (1 << LD) || NUM_CH < 1 || CLAMP_DELTA < 0) begin : g_bad_params
        $error("multi_channel_avg_filter: DEPTH must be a power of two, NUM_CH >= 1, CLAMP_DELTA >= 0");
    end
    logic [DATA_W-1:0] ring_q [NUM_CH][DEPTH];
    logic [DATA_W-1:0] ring_d [NUM_CH][DEPTH];
    logic [LD-1:0]     wptr_q [NUM_CH];
    logic [LD-1:0]     wptr_d [NUM_CH];
    logic [SUM_W-1:0]  sum_q [NUM_CH];
    logic [SUM_W-1:0]  sum_d [NUM_CH];
    logic [LD:0]       cnt_q [NUM_CH];
    logic [LD:0]       cnt_d [NUM_CH];
    logic              out_valid_q, out_valid_d, out_primed_q, out_primed_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [DATA_W-1:0] out_avg_q, out_avg_d, smp;
    logic [NUM_CH-1:0] primed_q, primed_d;
    logic [SUM_W-1:0]  sum_nx;
    logic [LD:0]       cnt_nx;
    logic              in_ok, clr_ok;
    // A clear of the sample's own channel wins and drops the sample.
    assign in_ok = in_valid && 32'(in_ch) < NUM_CH && !(clr_valid && clr_ch == in_ch);
    assign clr_ok = clr_valid && 32'(clr_ch) < NUM_CH;
`ifdef SPIKE_CLAMP_EN
    int avg_i, lo_i, hi_i;
    always_comb begin
        avg_i = int'(sum_q[in_ch] >> LD);
        lo_i = avg_i > CLAMP_DELTA ? avg_i - CLAMP_DELTA : 0;
        hi_i = avg_i + CLAMP_DELTA > (1 << DATA_W) - 1 ? (1 << DATA_W) - 1 : avg_i + CLAMP_DELTA;
        smp = cnt_q[in_ch] != FULL ? in_data :
              int'(in_data) < lo_i ? DATA_W'(lo_i) :
              int'(in_data) > hi_i ? DATA_W'(hi_i) : in_data;
    end
`else
    assign smp = in_data;
`endif
    always_comb begin
        ring_d = ring_q;
        wptr_d = wptr_q;
        sum_d = sum_q;
        cnt_d = cnt_q;
        primed_d = '0;
        sum_nx = sum_q[in_ch] - SUM_W'(ring_q[in_ch][wptr_q[in_ch]]) + SUM_W'(smp);
        cnt_nx = cnt_q[in_ch] == FULL ? FULL : cnt_q[in_ch] + 1'b1;
        if (in_ok) begin
            ring_d[in_ch][wptr_q[in_ch]] = smp;
            wptr_d[in_ch] = wptr_q[in_ch] + 1'b1;
            sum_d[in_ch] = sum_nx;
            cnt_d[in_ch] = cnt_nx;
        end
        if (clr_ok) begin
            ring_d[clr_ch] = '{default: '0};
            wptr_d[clr_ch] = '0;
            sum_d[clr_ch] = '0;
            cnt_d[clr_ch] = '0;
        end
        for (int i = 0; i < NUM_CH; i++) primed_d[i] = cnt_d[i] == FULL;
        out_valid_d = in_ok;
        out_ch_d = in_ok ? in_ch : out_ch_q;
        out_avg_d = in_ok ? DATA_W'(sum_nx >> LD) : out_avg_q;
        out_primed_d = in_ok ? cnt_nx == FULL : out_primed_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ring_q <= '{default: '0};
            wptr_q <= '{default: '0};
            sum_q <= '{default: '0};
            cnt_q <= '{default: '0};
            primed_q <= '0;
            out_valid_q <= 1'b0;
            out_ch_q <= '0;
            out_avg_q <= '0;
            out_primed_q <= 1'b0;
        end else begin
            ring_q <= ring_d;
            wptr_q <= wptr_d;
            sum_q <= sum_d;
            cnt_q <= cnt_d;
            primed_q <= primed_d;
            out_valid_q <= out_valid_d;
            out_ch_q <= out_ch_d;
            out_avg_q <= out_avg_d;
            out_primed_q <= out_primed_d;
        end
    end
    assign out_valid = out_valid_q;
    assign out_ch = out_ch_q;
    assign out_avg = out_avg_q;
    assign out_primed = out_primed_q;
    assign primed_mask = primed_q;
endmodule

// File: tb/tb_multi_channel_avg_filter.sv
// tb_multi_channel_avg_filter: directed checks of the default 2-channel filter and a wide 3-channel instance.
module tb_multi_channel_avg_filter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    logic       a_in_valid, a_in_ch, a_clr_valid, a_clr_ch, a_out_valid, a_out_ch, a_out_primed;
    logic [7:0] a_in_data, a_out_avg;
    logic [1:0] a_primed_mask;
    multi_channel_avg_filter u_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ch(a_in_ch), .in_data(a_in_data),
        .clr_valid(a_clr_valid), .clr_ch(a_clr_ch),
        .out_valid(a_out_valid), .out_ch(a_out_ch), .out_avg(a_out_avg),
        .out_primed(a_out_primed), .primed_mask(a_primed_mask)
    );
    logic        b_in_valid, b_clr_valid, b_out_valid, b_out_primed;
    logic [1:0]  b_in_ch, b_clr_ch, b_out_ch;
    logic [15:0] b_in_data, b_out_avg;
    logic [2:0]  b_primed_mask;
    multi_channel_avg_filter #(.NUM_CH(3), .DATA_W(16), .DEPTH(64)) u_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ch(b_in_ch), .in_data(b_in_data),
        .clr_valid(b_clr_valid), .clr_ch(b_clr_ch),
        .out_valid(b_out_valid), .out_ch(b_out_ch), .out_avg(b_out_avg),
        .out_primed(b_out_primed), .primed_mask(b_primed_mask)
    );
    int n_cmp = 0;
    int n_bad = 0;
    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask
    // Drive one sample on instance A at a falling edge, check its result one cycle later.
    task automatic smp_a(input logic ch, input logic [7:0] d, input int ea, input logic ep, input string tag);
        a_in_valid = 1'b1;
        a_in_ch = ch;
        a_in_data = d;
        @(negedge clk);
        a_in_valid = 1'b0;
        chk({tag, " valid"}, 32'(a_out_valid), 1);
        chk({tag, " ch"}, 32'(a_out_ch), 32'(ch));
        chk({tag, " avg"}, 32'(a_out_avg), ea);
        chk({tag, " primed"}, 32'(a_out_primed), 32'(ep));
    endtask
    initial begin
        reset = 1'b1;
        {a_in_valid, a_in_ch, a_in_data, a_clr_valid, a_clr_ch} = '0;
        {b_in_valid, b_in_ch, b_in_data, b_clr_valid, b_clr_ch} = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst valid", 32'(a_out_valid), 0);
        chk("rst avg", 32'(a_out_avg), 0);
        chk("rst mask", 32'(a_primed_mask), 0);
        chk("rst b mask", 32'(b_primed_mask), 0);
        for (int k = 1; k <= 8; k++) smp_a(1'b0, 8'd80, 10 * k, k == 8, $sformatf("fill80_%0d", k));
        chk("fill80 mask", 32'(a_primed_mask), 1);
        for (int k = 1; k <= 8; k++) smp_a(1'b0, 8'd0, 80 - 10 * k, 1'b1, $sformatf("drain_%0d", k));
        for (int k = 1; k <= 16; k++) begin
            smp_a(1'b0, 8'd200, (k < 8 ? k : 8) * 25, 1'b1, $sformatf("il_ch0_%0d", k));
            smp_a(1'b1, 8'd40, (k < 8 ? k : 8) * 5, k >= 8, $sformatf("il_ch1_%0d", k));
        end
        chk("il mask", 32'(a_primed_mask), 3);
        a_in_valid = 1'b1;
        a_in_ch = 1'b1;
        a_in_data = 8'd99;
        a_clr_valid = 1'b1;
        a_clr_ch = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0;
        a_clr_valid = 1'b0;
        chk("clr same valid", 32'(a_out_valid), 0);
        chk("clr same hold avg", 32'(a_out_avg), 40);
        chk("clr same mask", 32'(a_primed_mask), 1);
        smp_a(1'b0, 8'd200, 200, 1'b1, "clr ch0 kept");
        smp_a(1'b1, 8'd64, 8, 1'b0, "clr ch1 restart");
        a_clr_valid = 1'b1;
        a_clr_ch = 1'b0;
        smp_a(1'b1, 8'd64, 16, 1'b0, "clr other");
        a_clr_valid = 1'b0;
        chk("clr other mask", 32'(a_primed_mask), 0);
        for (int k = 1; k <= 8; k++) smp_a(1'b0, 8'd100, (100 * k) / 8, k == 8, $sformatf("fill100_%0d", k));
`ifdef SPIKE_CLAMP_EN
        smp_a(1'b0, 8'd250, 102, 1'b1, "spike");
`else
        smp_a(1'b0, 8'd250, 118, 1'b1, "spike");
`endif
        b_in_valid = 1'b1;
        b_in_ch = 2'd3;
        b_in_data = 16'hffff;
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("bad ch valid", 32'(b_out_valid), 0);
        chk("bad ch avg", 32'(b_out_avg), 0);
        chk("bad ch mask", 32'(b_primed_mask), 0);
        for (int k = 1; k <= 64; k++) begin
            b_in_valid = 1'b1;
            b_in_ch = 2'd0;
            b_in_data = 16'hffff;
            @(negedge clk);
            b_in_valid = 1'b0;
            if (k == 1) chk("wide first avg", 32'(b_out_avg), 1023);
            if (k == 63) begin
                chk("wide 63 avg", 32'(b_out_avg), 64511);
                chk("wide 63 primed", 32'(b_out_primed), 0);
            end
            if (k == 64) begin
                chk("wide full valid", 32'(b_out_valid), 1);
                chk("wide full avg", 32'(b_out_avg), 65535);
                chk("wide full primed", 32'(b_out_primed), 1);
            end
        end
        @(negedge clk);
        chk("wide mask", 32'(b_primed_mask), 1);
        chk("wide pulse", 32'(b_out_valid), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
